decode_stage_pipe: RTL and testbench
====================================

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and bus width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning register count (power of two, 2..32); RA_W = log2(NREGS).
REQ-003 The block SHALL have parameter PC_W, default 10, meaning PC and branch/jump address width.
REQ-004 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port instruc  input  32  instruction held in the IF/ID register.
REQ-007 Port id_valid  input  1  instruc is a real instruction, not a bubble.
REQ-008 Port current_PC  input  PC_W  PC of instruc.
REQ-009 Port flush  input  1  squash the instruction entering ID/EX.
REQ-010 Port reg_write, rw, busw  input  1, RA_W, DATA_W  writeback enable, address and data.
REQ-011 Port stall  output  1  hold PC and IF/ID this cycle (combinational).
REQ-012 Port branch_sel, jump_sel  output  1 each  redirect fetch (combinational).
REQ-013 Port branch_address, jump_address  output  PC_W each  redirect targets (combinational).
REQ-014 Port ex_control, m_control, wb_control  output  4, 2, 2  registered ID/EX control.
REQ-015 Port ex_bus_a, ex_bus_b, ex_immed  output  DATA_W each  registered operands and sign-extended immediate.
REQ-016 Port ex_rs, ex_rt, ex_rd  output  RA_W each  registered register specifiers.

Function
REQ-017 Decode SHALL use instruc[31:26]: 000000 R-type -> ex 1010, m 00, wb 10; 100011 lw -> ex 0100, m 10, wb 11; 101011 sw -> ex 0100, m 01, wb 00; 001000 addi -> ex 0100, m 00, wb 10; 000100 beq, 000101 bne, 000010 j and any other opcode -> all-zero control.
REQ-018 Control bit meanings SHALL be ex[3] reg_dst, ex[2] alu_src, ex[1:0] alu_op; m[1] mem_read, m[0] mem_write; wb[1] reg_write, wb[0] mem_to_reg.
REQ-019 The register file SHALL hold NREGS entries of DATA_W bits, read ra=instruc[25:21] and rb=instruc[20:16] (low RA_W bits) combinationally, and write busw to rw on the clock edge when reg_write=1.
REQ-020 Register 0 SHALL always read zero, and writes to it SHALL be ignored.
REQ-021 The immediate SHALL be instruc[15:0] sign-extended to DATA_W.
REQ-022 Load-use hazard: stall SHALL be 1 when id_valid=1, m_control[1]=1, ex_rt!=0 and ex_rt equals ra or rb; otherwise stall SHALL be 0.
REQ-023 branch_sel SHALL be 1 when id_valid=1, stall=0, and either (beq and bus_a==bus_b) or (bne and bus_a!=bus_b).
REQ-024 branch_address SHALL be current_PC + immed[PC_W-1:0], wrapping modulo 2^PC_W.
REQ-025 jump_sel SHALL be 1 when id_valid=1, stall=0 and the opcode is j.
REQ-026 jump_address SHALL be instruc[PC_W-1:0].
REQ-027 The ID/EX register SHALL load its update with priority reset > flush > (stall or !id_valid) bubble > normal.
REQ-028 A bubble SHALL load all-zero control while data fields load normally; normal loads decoded control, operands, immediate, rs, rt and rd=instruc[15:11].
REQ-029 Latency SHALL be one cycle from instruc to the ex_* outputs; a stalled instruction SHALL issue on the cycle after its stall.

Reset
REQ-030 With reset=1 at a clock edge, all ex_*, m_control and wb_control registers SHALL clear to 0 and all register-file entries SHALL clear to 0.
REQ-031 Reset asserted mid-stall SHALL clear ID/EX, so stall SHALL be 0 in the following cycle.

Configuration
REQ-032 Macro WB_BYPASS_EN, when defined, SHALL make a register read return busw in the same cycle when reg_write=1, rw!=0 and rw equals the read address; this applies to operands and to the branch compare.
REQ-033 When WB_BYPASS_EN is undefined, reads SHALL return the pre-write register contents.

Verification
REQ-034 Scenario: write r5=0x11 -> next cycle `add r3,r5,r5` -> one cycle later ex_bus_a=ex_bus_b=0x11, ex_control=1010, wb_control=10.
REQ-035 Scenario: `lw r4` in ID/EX with `add r2,r4,r1` in ID -> stall=1 for one cycle and bubble control 0; the next cycle the add issues with stall=0.
REQ-036 Scenario: beq with r1=r2=7, current_PC=0x3FE, immed=4 -> branch_sel=1, branch_address=0x002; with r2=8 -> branch_sel=0.
REQ-037 Scenario: `j` with instruc[9:0]=0x155 -> jump_sel=1, jump_address=0x155; flush the same cycle -> ID/EX controls are 0.
REQ-038 Scenario: with WB_BYPASS_EN, reg_write=1, rw=6, busw=0xAB and `addi` reading r6 in the same cycle -> ex_bus_a=0xAB; without the macro -> the old r6 value.
REQ-039 Scenario: reset asserted during a stall -> all outputs 0 the next cycle; a write to r0 followed by a read of r0 -> 0.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file, control decode, load-use stall, branch/jump resolve, ID/EX register.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data to the register read ports.
module decode_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int PC_W   = 10,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruc,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   current_PC,
  input  logic              flush,
  input  logic              reg_write,
  input  logic [RA_W-1:0]   rw,
  input  logic [DATA_W-1:0] busw,
  output logic              stall,
  output logic              branch_sel,
  output logic              jump_sel,
  output logic [PC_W-1:0]   branch_address,
  output logic [PC_W-1:0]   jump_address,
  output logic [3:0]        ex_control,
  output logic [1:0]        m_control,
  output logic [1:0]        wb_control,
  output logic [DATA_W-1:0] ex_bus_a,
  output logic [DATA_W-1:0] ex_bus_b,
  output logic [DATA_W-1:0] ex_immed,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  opcode_e             opcode;
  logic [RA_W-1:0]     ra, rb, rd;
  logic [DATA_W-1:0]   bus_a, bus_b, immed;
  logic [3:0]          dec_ex;
  logic [1:0]          dec_m, dec_wb;
  logic                issue;

  logic [DATA_W-1:0]   rf_q [NREGS];

  logic [3:0]          ex_ctrl_q, ex_ctrl_d;
  logic [1:0]          m_ctrl_q, m_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [DATA_W-1:0]   bus_a_q, bus_a_d, bus_b_q, bus_b_d, immed_q, immed_d;
  logic [RA_W-1:0]     rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

  assign opcode = opcode_e'(instruc[31:26]);
  assign ra     = instruc[21 +: RA_W];
  assign rb     = instruc[16 +: RA_W];
  assign rd     = instruc[11 +: RA_W];
  assign immed  = {{(DATA_W-16){instruc[15]}}, instruc[15:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (reg_write && rw != '0) begin
      rf_q[rw] <= busw;
    end
  end

  always_comb begin
    bus_a = (ra == '0) ? '0 : rf_q[ra];
`ifdef WB_BYPASS_EN
    if (reg_write && rw != '0 && rw == ra) bus_a = busw;
`endif
  end

  always_comb begin
    bus_b = (rb == '0) ? '0 : rf_q[rb];
`ifdef WB_BYPASS_EN
    if (reg_write && rw != '0 && rw == rb) bus_b = busw;
`endif
  end

  always_comb begin
    dec_ex = '0;
    dec_m  = '0;
    dec_wb = '0;
    case (opcode)
      OP_RTYPE: begin dec_ex = 4'b1010; dec_wb = 2'b10; end
      OP_LW:    begin dec_ex = 4'b0100; dec_m = 2'b10; dec_wb = 2'b11; end
      OP_SW:    begin dec_ex = 4'b0100; dec_m = 2'b01; end
      OP_ADDI:  begin dec_ex = 4'b0100; dec_wb = 2'b10; end
      default:  ;
    endcase
  end

  assign stall = id_valid && m_ctrl_q[1] && (rt_q != '0) && ((rt_q == ra) || (rt_q == rb));
  assign issue = id_valid && !stall;

  assign branch_sel     = issue && (((opcode == OP_BEQ) && (bus_a == bus_b)) ||
                                    ((opcode == OP_BNE) && (bus_a != bus_b)));
  assign branch_address = current_PC + immed[PC_W-1:0];
  assign jump_sel       = issue && (opcode == OP_J);
  assign jump_address   = instruc[PC_W-1:0];

  // Flush and bubble both zero only the control fields; operand fields always load.
  always_comb begin
    ex_ctrl_d = dec_ex;
    m_ctrl_d  = dec_m;
    wb_ctrl_d = dec_wb;
    if (flush || stall || !id_valid) begin
      ex_ctrl_d = '0;
      m_ctrl_d  = '0;
      wb_ctrl_d = '0;
    end
    bus_a_d = bus_a;
    bus_b_d = bus_b;
    immed_d = immed;
    rs_d    = ra;
    rt_d    = rb;
    rd_d    = rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ctrl_q <= '0;
      m_ctrl_q  <= '0;
      wb_ctrl_q <= '0;
      bus_a_q   <= '0;
      bus_b_q   <= '0;
      immed_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ex_ctrl_q <= ex_ctrl_d;
      m_ctrl_q  <= m_ctrl_d;
      wb_ctrl_q <= wb_ctrl_d;
      bus_a_q   <= bus_a_d;
      bus_b_q   <= bus_b_d;
      immed_q   <= immed_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  assign ex_control = ex_ctrl_q;
  assign m_control  = m_ctrl_q;
  assign wb_control = wb_ctrl_q;
  assign ex_bus_a   = bus_a_q;
  assign ex_bus_b   = bus_b_q;
  assign ex_immed   = immed_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe with default parameters; expectations hand-computed.
module tb_decode_stage_pipe;

  logic        clock = 1'b0;
  logic        reset, id_valid, flush, reg_write;
  logic [31:0] instruc, busw;
  logic [9:0]  current_PC;
  logic [4:0]  rw;
  logic        stall, branch_sel, jump_sel;
  logic [9:0]  branch_address, jump_address;
  logic [3:0]  ex_control;
  logic [1:0]  m_control, wb_control;
  logic [31:0] ex_bus_a, ex_bus_b, ex_immed;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  int errors = 0;
  int checks = 0;

  decode_stage_pipe #(.DATA_W(32), .NREGS(32), .PC_W(10)) dut (
    .clock(clock), .reset(reset), .instruc(instruc), .id_valid(id_valid),
    .current_PC(current_PC), .flush(flush), .reg_write(reg_write), .rw(rw), .busw(busw),
    .stall(stall), .branch_sel(branch_sel), .jump_sel(jump_sel),
    .branch_address(branch_address), .jump_address(jump_address),
    .ex_control(ex_control), .m_control(m_control), .wb_control(wb_control),
    .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b), .ex_immed(ex_immed),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    id_valid = 1'b0; instruc = '0; reg_write = 1'b1; rw = a; busw = d;
    step();
    reg_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; flush = 1'b0; reg_write = 1'b0;
    instruc = '0; busw = '0; rw = '0; current_PC = '0;
    step();
    check("reset_ex_control", ex_control, 4'b0000);
    check("reset_m_control", m_control, 2'b00);
    check("reset_wb_control", wb_control, 2'b00);
    check("reset_bus_a", ex_bus_a, 32'h0);
    check("reset_stall", stall, 1'b0);
    reset = 1'b0;

    // write r5 then add r3,r5,r5
    wr(5'd5, 32'h11);
    instruc = rtype(5'd5, 5'd5, 5'd3); id_valid = 1'b1;
    #1 check("add_stall", stall, 1'b0);
    step();
    check("add_bus_a", ex_bus_a, 32'h11);
    check("add_bus_b", ex_bus_b, 32'h11);
    check("add_ex_control", ex_control, 4'b1010);
    check("add_m_control", m_control, 2'b00);
    check("add_wb_control", wb_control, 2'b10);
    check("add_rd", ex_rd, 5'd3);

    wr(5'd1, 32'h7);
    wr(5'd2, 32'h7);
    wr(5'd4, 32'h40);

    // load-use hazard
    instruc = itype(6'b100011, 5'd0, 5'd4, 16'h0008); id_valid = 1'b1;
    step();
    check("lw_ex_control", ex_control, 4'b0100);
    check("lw_m_control", m_control, 2'b10);
    check("lw_wb_control", wb_control, 2'b11);
    check("lw_rt", ex_rt, 5'd4);
    check("lw_immed", ex_immed, 32'h8);
    instruc = rtype(5'd4, 5'd1, 5'd2);
    #1 check("lu_stall", stall, 1'b1);
    step();
    check("bubble_ex_control", ex_control, 4'b0000);
    check("bubble_m_control", m_control, 2'b00);
    check("bubble_wb_control", wb_control, 2'b00);
    check("bubble_stall_clear", stall, 1'b0);
    step();
    check("lu_add_ex_control", ex_control, 4'b1010);
    check("lu_add_bus_a", ex_bus_a, 32'h40);
    check("lu_add_bus_b", ex_bus_b, 32'h7);
    check("lu_add_rd", ex_rd, 5'd2);

    // lw r0 does not create a hazard
    instruc = itype(6'b100011, 5'd0, 5'd0, 16'h0000);
    step();
    instruc = rtype(5'd0, 5'd0, 5'd3);
    #1 check("lw_r0_no_stall", stall, 1'b0);
    step();

    // branches
    instruc = itype(6'b000100, 5'd1, 5'd2, 16'h0004); current_PC = 10'h3FE;
    #1 check("beq_taken", branch_sel, 1'b1);
    check("beq_addr_wrap", branch_address, 10'h002);
    check("beq_no_jump", jump_sel, 1'b0);
    step();
    check("beq_ex_control", ex_control, 4'b0000);
    check("beq_immed", ex_immed, 32'h4);
    wr(5'd2, 32'h8);
    instruc = itype(6'b000100, 5'd1, 5'd2, 16'h0004); id_valid = 1'b1;
    #1 check("beq_not_taken", branch_sel, 1'b0);
    instruc = itype(6'b000101, 5'd1, 5'd2, 16'hFFFE); current_PC = 10'h001;
    #1 check("bne_taken", branch_sel, 1'b1);
    check("bne_addr_neg", branch_address, 10'h3FF);
    id_valid = 1'b0;
    #1 check("bne_invalid", branch_sel, 1'b0);
    id_valid = 1'b1;
    step();
    check("neg_immed_sext", ex_immed, 32'hFFFF_FFFE);

    // jump with flush, then flush of a load
    instruc = {6'b000010, 26'h0000155}; flush = 1'b1;
    #1 check("j_sel", jump_sel, 1'b1);
    check("j_addr", jump_address, 10'h155);
    step();
    check("j_flush_ex", ex_control, 4'b0000);
    check("j_flush_wb", wb_control, 2'b00);
    instruc = itype(6'b100011, 5'd0, 5'd9, 16'h0000);
    step();
    check("lw_flush_m", m_control, 2'b00);
    check("lw_flush_wb", wb_control, 2'b00);
    flush = 1'b0;

    // same-cycle writeback vs read of r6
    wr(5'd6, 32'h22);
    instruc = itype(6'b001000, 5'd6, 5'd7, 16'h0005); id_valid = 1'b1;
    reg_write = 1'b1; rw = 5'd6; busw = 32'hAB;
    step();
    reg_write = 1'b0;
`ifdef WB_BYPASS_EN
    check("addi_bus_a_bypass", ex_bus_a, 32'hAB);
`else
    check("addi_bus_a_old", ex_bus_a, 32'h22);
`endif
    check("addi_ex_control", ex_control, 4'b0100);
    check("addi_wb_control", wb_control, 2'b10);
    check("addi_immed", ex_immed, 32'h5);
    step();
    check("addi_bus_a_after", ex_bus_a, 32'hAB);

    // reset during a stall
    instruc = itype(6'b100011, 5'd0, 5'd4, 16'h0010);
    step();
    instruc = rtype(5'd4, 5'd1, 5'd2);
    #1 check("rst_pre_stall", stall, 1'b1);
    reset = 1'b1;
    step();
    check("rst_ex_control", ex_control, 4'b0000);
    check("rst_m_control", m_control, 2'b00);
    check("rst_wb_control", wb_control, 2'b00);
    check("rst_bus_a", ex_bus_a, 32'h0);
    check("rst_immed", ex_immed, 32'h0);
    check("rst_rt", ex_rt, 5'd0);
    check("rst_stall", stall, 1'b0);
    reset = 1'b0;
    instruc = itype(6'b001000, 5'd5, 5'd7, 16'h0000);
    step();
    check("rst_rf_cleared", ex_bus_a, 32'h0);

    // r0 ignores writes
    wr(5'd0, 32'hFF);
    instruc = rtype(5'd0, 5'd0, 5'd3); id_valid = 1'b1;
    step();
    check("r0_bus_a", ex_bus_a, 32'h0);
    check("r0_bus_b", ex_bus_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
